// File: rtl/fpu_issue_controller.sv
// Issue controller in front of Fixed_Point_Unit: accepts one operation per request, holds
// operands stable until the unit reports ready, and returns the result with its tag.
module fpu_issue_controller #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_operand_1,
    input  logic [WIDTH-1:0] req_operand_2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [1:0]       fpu_operation,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam logic [1:0] FPU_ADD  = 2'b00;
    localparam logic [1:0] FPU_SUB  = 2'b01;
    localparam logic [1:0] FPU_MUL  = 2'b10;
    localparam logic [1:0] FPU_SQRT = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int                CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd1_q, opnd1_d;
    logic [WIDTH-1:0] opnd2_q, opnd2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd1_d   = opnd1_q;
        opnd2_d   = opnd2_q;
        tag_d     = tag_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    opnd1_d = req_operand_1;
                    opnd2_d = req_operand_2;
                    tag_d   = req_tag;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An X or Z on fpu_ready must not complete the operation.
                if (fpu_ready == 1'b1) begin
                    result_d  = fpu_result;
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= FPU_ADD;
            opnd1_q   <= '0;
            opnd2_q   <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd1_q   <= opnd1_d;
            opnd2_q   <= opnd2_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outside ISSUE/WAIT the unit sees ADD so its MUL/SQRT stage machines fall back to idle.
    assign fpu_operation = (state_q == S_ISSUE || state_q == S_WAIT) ? op_q : FPU_ADD;
    assign fpu_operand_1 = opnd1_q;
    assign fpu_operand_2 = opnd2_q;

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_DONE);
    assign rsp_result  = result_q;
    assign rsp_tag     = tag_q;
    assign rsp_timeout = timeout_q;
    assign busy        = (state_q != S_IDLE);

endmodule
